// File: rtl/bram16_copy_engine_if.sv
// Control and memory-bus bundle for bram16_copy_engine.
//   master : the copy engine (drives status and the RAM address/write side)
//   slave  : the environment (control registers plus the attached bram16)
// Control: start/mode/src/dst/len/pattern in; busy/done/words_done out.
// Memory : mem_a/mem_we/mem_do out; mem_di is the RAM's registered read data.
interface bram16_copy_engine_if;
  logic        start;
  logic        mode;
  logic [15:0] src;
  logic [15:0] dst;
  logic [15:0] len;
  logic [15:0] pattern;
  logic        busy;
  logic        done;
  logic [15:0] words_done;
  logic [15:0] mem_a;
  logic        mem_we;
  logic [15:0] mem_do;
  logic [15:0] mem_di;

  modport master (
    input  start, mode, src, dst, len, pattern, mem_di,
    output busy, done, words_done, mem_a, mem_we, mem_do
  );

  modport slave (
    output start, mode, src, dst, len, pattern, mem_di,
    input  busy, done, words_done, mem_a, mem_we, mem_do
  );
endinterface

// File: rtl/bram16_copy_engine.sv
// Block copy / block fill engine for a 16-bit single-port block RAM.
//   sys_clk : rising-edge clock
//   sys_rst : asynchronous active-low reset
//   bus     : master side of bram16_copy_engine_if
//             (start/mode/src/dst/len/pattern in, busy/done/words_done out,
//              mem_a/mem_we/mem_do out, mem_di in)
// Copy alternates RD (present source address) and WR (write the registered
// read data to the destination), 2 cycles per word. Fill stays in WR and
// writes one pattern word per cycle. Pointers wrap modulo 2^16.
module bram16_copy_engine #(
  parameter int adr_width = 11  // width of the attached RAM; mem_a stays 16 bits
) (
  input logic                          sys_clk,
  input logic                          sys_rst,
  bram16_copy_engine_if.master         bus
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  typedef struct packed {
    logic        mode;     // 0 = copy, 1 = fill
    logic [15:0] len;
    logic [15:0] pattern;
  } req_t;

  state_t      state;
  req_t        req_q;
  logic [15:0] src_ptr;
  logic [15:0] dst_ptr;
  logic [15:0] words_done;
  logic        done;
  logic [15:0] words_nxt;

  assign words_nxt = words_done + 16'd1;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= IDLE;
      req_q      <= '0;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      words_done <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            req_q      <= '{mode: bus.mode, len: bus.len, pattern: bus.pattern};
            src_ptr    <= bus.src;
            dst_ptr    <= bus.dst;
            words_done <= '0;
            // Zero-length requests complete without touching memory.
            if (bus.len == 16'd0) done  <= 1'b1;
            else                  state <= bus.mode ? WR : RD;
          end
        end
        RD: state <= WR;
        WR: begin
          dst_ptr    <= dst_ptr + 16'd1;
          words_done <= words_nxt;
          if (!req_q.mode) src_ptr <= src_ptr + 16'd1;
          // Compare against the incremented count so len=0xFFFF cannot overflow.
          if (words_nxt == req_q.len) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            state <= req_q.mode ? WR : RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs decode straight from the state register, so the asynchronous
  // reset drops mem_we in the same instant it forces IDLE.
  always_comb begin
    bus.mem_a  = '0;
    bus.mem_we = 1'b0;
    bus.mem_do = '0;
    case (state)
      RD: bus.mem_a = src_ptr;
      WR: begin
        bus.mem_a  = dst_ptr;
        bus.mem_we = 1'b1;
        bus.mem_do = req_q.mode ? req_q.pattern : bus.mem_di;
      end
      default: ;
    endcase
  end

  assign bus.busy       = (state == RD) || (state == WR);
  assign bus.done       = done;
  assign bus.words_done = words_done;

endmodule

// File: tb/tb_bram16_copy_engine.sv
module tb_bram16_copy_engine;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  always #5 sys_clk = ~sys_clk;

  bram16_copy_engine_if bus ();

  bram16_copy_engine #(.adr_width(11)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.master)
  );

  // Behavioural RAM: full 64K words so address wrap is visible exactly.
  logic [15:0] ram     [0:65535] = '{default: 16'h0};
  logic [15:0] ref_mem [0:65535] = '{default: 16'h0};

  always @(posedge sys_clk) begin
    if (bus.mem_we) ram[bus.mem_a] <= bus.mem_do;
    bus.mem_di <= ram[bus.mem_a];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Activity monitor
  int busy_cnt, done_cnt, we_cnt;
  logic [15:0] wr_q[$];

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      if (bus.busy)   busy_cnt++;
      if (bus.done)   done_cnt++;
      if (bus.mem_we) begin
        we_cnt++;
        wr_q.push_back(bus.mem_a);
      end
    end
  end

  // Reference: ascending word-by-word semantics, 16-bit wrapping addresses.
  task automatic model_op(input bit m, input logic [15:0] s, d, l, p);
    for (int i = 0; i < int'(l); i++) begin
      logic [15:0] sa, da;
      sa = s + 16'(i);
      da = d + 16'(i);
      ref_mem[da] = m ? p : ref_mem[sa];
    end
  endtask

  task automatic cmp_mem(input string tag);
    int diffs = 0;
    for (int i = 0; i < 65536; i++)
      if (ram[i] !== ref_mem[i]) diffs++;
    chk(tag, diffs, 0);
  endtask

  task automatic clr_mon();
    busy_cnt = 0; done_cnt = 0; we_cnt = 0;
    wr_q.delete();
  endtask

  task automatic drive_req(input bit m, input logic [15:0] s, d, l, p);
    bus.start = 1'b1; bus.mode = m; bus.src = s; bus.dst = d;
    bus.len = l; bus.pattern = p;
  endtask

  // Wait (bounded) for done at a negedge; returns 1 if seen.
  task automatic wait_done(input int budget, output bit found);
    found = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge sys_clk);
      if (bus.done) begin found = 1; break; end
    end
  endtask

  // One full operation with timing/count/memory checks.
  // inj >= 0 pulses a bogus start that many cycles into the operation.
  task automatic run_op(input string tag, input bit m, input logic [15:0] s, d, l, p,
                        input int inj);
    bit found = 0;
    @(posedge sys_clk); #1;
    drive_req(m, s, d, l, p);
    clr_mon();
    @(posedge sys_clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 2 * int'(l) + 8; k++) begin
      @(negedge sys_clk);
      if (k == inj)     drive_req(1'b1, 16'h0, 16'h0099, 16'd5, 16'hDEAD);
      if (k == inj + 1) bus.start = 1'b0;
      if (bus.done) begin found = 1; break; end
    end
    bus.start = 1'b0;
    chk({tag, "_done_seen"}, int'(found), 1);
    @(negedge sys_clk);
    @(negedge sys_clk);
    model_op(m, s, d, l, p);
    chk({tag, "_busy_cycles"}, busy_cnt, m ? int'(l) : 2 * int'(l));
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_we_cycles"}, we_cnt, int'(l));
    chk({tag, "_words_done"}, int'(bus.words_done), int'(l));
    cmp_mem({tag, "_mem"});
  endtask

  initial begin
    bit found;
    bus.start = 0; bus.mode = 0; bus.src = 0; bus.dst = 0; bus.len = 0; bus.pattern = 0;

    // Reset values
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_words", int'(bus.words_done), 0);
    chk("rst_we", int'(bus.mem_we), 0);
    chk("rst_a", int'(bus.mem_a), 0);
    chk("rst_do", int'(bus.mem_do), 0);
    sys_rst = 1'b1;

    // Preload 0x10..0x13 with single-word fills, then basic copy
    for (int i = 0; i < 4; i++)
      run_op("preload", 1'b1, 16'h0, 16'h0010 + 16'(i), 16'd1, 16'hA001 + 16'(i), -1);
    run_op("copy4", 1'b0, 16'h0010, 16'h0040, 16'd4, 16'h0, -1);
    for (int i = 0; i < 4; i++)
      chk("copy4_word", int'(ram[16'h0040 + 16'(i)]), 32'hA001 + i);

    // Fill across the top of the address space
    run_op("fillwrap", 1'b1, 16'h0, 16'hFFFE, 16'd3, 16'h5A5A, -1);
    chk("fillwrap_nwr", wr_q.size(), 3);
    if (wr_q.size() == 3) begin
      chk("fillwrap_a0", int'(wr_q[0]), 32'hFFFE);
      chk("fillwrap_a1", int'(wr_q[1]), 32'hFFFF);
      chk("fillwrap_a2", int'(wr_q[2]), 32'h0000);
    end

    // Zero length, then a start ignored while busy
    run_op("len0", 1'b0, 16'h0010, 16'h0080, 16'd0, 16'h0, -1);
    for (int i = 0; i < 8; i++)
      run_op("seed", 1'b1, 16'h0, 16'h0200 + 16'(i), 16'd1, 16'($urandom), -1);
    run_op("ignored", 1'b0, 16'h0200, 16'h0300, 16'd8, 16'h0, 3);

    // Back-to-back: second start lands in the done cycle
    @(posedge sys_clk); #1;
    drive_req(1'b1, 16'h0, 16'h0700, 16'd2, 16'hC3C3);
    clr_mon();
    @(posedge sys_clk); #1;
    bus.start = 1'b0;
    wait_done(12, found);
    chk("b2b_first_done", int'(found), 1);
    drive_req(1'b0, 16'h0700, 16'h0710, 16'd3, 16'h0);
    @(posedge sys_clk); #1;
    bus.start = 1'b0;
    chk("b2b_busy_next", int'(bus.busy), 1);
    wait_done(20, found);
    chk("b2b_second_done", int'(found), 1);
    @(negedge sys_clk);
    @(negedge sys_clk);
    model_op(1'b1, 16'h0, 16'h0700, 16'd2, 16'hC3C3);
    model_op(1'b0, 16'h0700, 16'h0710, 16'd3, 16'h0);
    chk("b2b_done_pulses", done_cnt, 2);
    chk("b2b_busy_cycles", busy_cnt, 8);
    chk("b2b_words_done", int'(bus.words_done), 3);
    cmp_mem("b2b_mem");

    // Reset in the WR cycle of the third word of a len=10 copy
    for (int i = 0; i < 10; i++)
      run_op("seed2", 1'b1, 16'h0, 16'h0500 + 16'(i), 16'd1, 16'($urandom), -1);
    @(posedge sys_clk); #1;
    drive_req(1'b0, 16'h0500, 16'h0600, 16'd10, 16'h0);
    @(posedge sys_clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("midrst_pre_we", int'(bus.mem_we), 1);
    chk("midrst_pre_a", int'(bus.mem_a), 32'h0602);
    sys_rst = 1'b0;
    #1;
    chk("midrst_we", int'(bus.mem_we), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_words", int'(bus.words_done), 0);
    chk("midrst_a", int'(bus.mem_a), 0);
    model_op(1'b0, 16'h0500, 16'h0600, 16'd2, 16'h0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("postrst_busy", int'(bus.busy), 0);
    chk("postrst_done", int'(bus.done), 0);
    chk("postrst_we", int'(bus.mem_we), 0);
    cmp_mem("midrst_mem");
    run_op("postrst_copy", 1'b0, 16'h0500, 16'h0620, 16'd10, 16'h0, -1);

    // Randomized operations, including overlaps and wrap near the top
    for (int n = 0; n < 25; n++) begin
      logic [15:0] base, s, d, l;
      base = ($urandom_range(0, 3) == 0) ? 16'hFFE0 : 16'h0800;
      s = base + 16'($urandom_range(0, 47));
      d = base + 16'($urandom_range(0, 47));
      l = 16'($urandom_range(0, 16));
      run_op("rand", 1'($urandom), s, d, l, 16'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
